uart_rx_wb: RTL and testbench



---
 rtl/uart_rx_wb_if.sv | 22 ++
 rtl/uart_rx_wb.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_wb.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_wb_if.sv
// Wishbone slave bus bundle for the UART receiver: address, strobes, data and acknowledge.
// No logic of its own. Flow control is the ACK handshake that the slave drives.
// The master drives requests, and the slave returns read data and ACK.
interface uart_rx_wb_if;
    logic [3:0]  WBs_ADR_i;
    logic        WBs_CYC_i;
    logic        WBs_STB_i;
    logic        WBs_WE_i;
    logic [3:0]  WBs_BYTE_STB_i;
    logic [31:0] WBs_WR_DAT_i;
    logic [31:0] WBs_RD_DAT_o;
    logic        WBs_ACK_o;

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_WR_DAT_i,
        input  WBs_RD_DAT_o, WBs_ACK_o
    );
    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_STB_i, WBs_WE_i, WBs_BYTE_STB_i, WBs_WR_DAT_i,
        output WBs_RD_DAT_o, WBs_ACK_o
    );
endinterface

// File: rtl/uart_rx_wb.sv
// 8N1 UART receiver with 16x oversampling, a receive FIFO and a Wishbone register slave.
// Latency: ACK arrives 1 cycle after the request. A byte is pushed 1 cycle after its stop-bit sample.
// Backpressure: none on the serial side. A push into a full FIFO drops the byte and sets overrun.
module uart_rx_wb #(
    parameter int          FIFO_ADDR_W        = 4,
    parameter logic [15:0] DEFAULT_DIV        = 16'd1,
    parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADFABAC
) (
    input  logic        WB_CLK,
    input  logic        WB_RST_n,
    uart_rx_wb_if.slave wb,
    input  logic        SIN_i,
    output logic        Intr_o
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int CW    = FIFO_ADDR_W + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} rx_state_t;

    logic        ack_q;
    logic [31:0] rd_q, rd_val;
    logic        access, rd_acc, wr_acc, ctrl_wr, stat_wr, pop;
    logic [1:0]  reg_sel;

    logic [15:0] div_q, div_eff, baud_cnt_q;
    logic        rx_en_q, int_en_q, tick;
    logic [4:0]  thr_q;

    logic        sin_meta_q, line_q;

    rx_state_t   state_q, state_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  sh_q, sh_d;
    logic        push_q, push_d, fe_set;

    logic [7:0]             mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wptr_q, rptr_q;
    logic [CW-1:0]          count_q;
    logic                   full, push_ok, ovr_set;
    logic                   ovr_q, fe_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, wb.WBs_ADR_i[1:0], wb.WBs_WR_DAT_i[31:25], wb.WBs_WR_DAT_i[19:18]};

    assign access  = wb.WBs_CYC_i & wb.WBs_STB_i & ~ack_q;
    assign rd_acc  = access & ~wb.WBs_WE_i;
    assign wr_acc  = access & wb.WBs_WE_i;
    assign reg_sel = wb.WBs_ADR_i[3:2];
    assign ctrl_wr = wr_acc && (reg_sel == 2'd2);
    assign stat_wr = wr_acc && (reg_sel == 2'd1);
    assign pop     = rd_acc && (reg_sel == 2'd0) && (count_q != '0);

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            div_q    <= DEFAULT_DIV;
            rx_en_q  <= 1'b0;
            int_en_q <= 1'b0;
            thr_q    <= 5'd1;
        end else if (ctrl_wr) begin
            if (wb.WBs_BYTE_STB_i[0]) div_q[7:0]  <= wb.WBs_WR_DAT_i[7:0];
            if (wb.WBs_BYTE_STB_i[1]) div_q[15:8] <= wb.WBs_WR_DAT_i[15:8];
            if (wb.WBs_BYTE_STB_i[2]) begin
                rx_en_q    <= wb.WBs_WR_DAT_i[16];
                int_en_q   <= wb.WBs_WR_DAT_i[17];
                thr_q[3:0] <= wb.WBs_WR_DAT_i[23:20];
            end
            if (wb.WBs_BYTE_STB_i[3]) thr_q[4] <= wb.WBs_WR_DAT_i[24];
        end
    end

    // A divisor of zero runs at the same rate as a divisor of one.
    assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign tick    = rx_en_q && (baud_cnt_q == div_eff - 16'd1);

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            baud_cnt_q <= '0;
            sin_meta_q <= 1'b1;
            line_q     <= 1'b1;
        end else begin
            sin_meta_q <= SIN_i;
            line_q     <= sin_meta_q;
            if (!rx_en_q || ctrl_wr || tick) baud_cnt_q <= '0;
            else                             baud_cnt_q <= baud_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            state_q <= ST_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
            push_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bcnt_q  <= bcnt_d;
            sh_q    <= sh_d;
            push_q  <= push_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bcnt_d  = bcnt_q;
        sh_d    = sh_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        if (!rx_en_q) begin
            state_d = ST_IDLE;
        end else if (tick) begin
            unique case (state_q)
                ST_IDLE: if (!line_q) begin
                    state_d = ST_START;
                    tcnt_d  = '0;
                end
                // Mid-start-bit recheck; a line that is high again was only a glitch.
                ST_START: if (tcnt_q == 4'd7) begin
                    state_d = line_q ? ST_IDLE : ST_DATA;
                    tcnt_d  = '0;
                    bcnt_d  = '0;
                end else tcnt_d = tcnt_q + 4'd1;
                ST_DATA: if (tcnt_q == 4'd15) begin
                    sh_d   = {line_q, sh_q[7:1]};
                    tcnt_d = '0;
                    if (bcnt_q == 3'd7) state_d = ST_STOP;
                    else                bcnt_d  = bcnt_q + 3'd1;
                end else tcnt_d = tcnt_q + 4'd1;
                ST_STOP: if (tcnt_q == 4'd15) begin
                    tcnt_d = '0;
                    if (line_q) begin
                        push_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else tcnt_d = tcnt_q + 4'd1;
                ST_BREAK: if (line_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO is not an overrun then.
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push_q & (~full | pop);
    assign ovr_set = push_q & full & ~pop;

    always_ff @(posedge WB_CLK) begin
        if (push_ok) mem[wptr_q] <= sh_q;
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            if (push_ok && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push_ok) count_q <= count_q - 1'b1;
            ovr_q <= ovr_set | (ovr_q & ~(stat_wr & wb.WBs_BYTE_STB_i[1] & wb.WBs_WR_DAT_i[8]));
            fe_q  <= fe_set  | (fe_q  & ~(stat_wr & wb.WBs_BYTE_STB_i[1] & wb.WBs_WR_DAT_i[9]));
        end
    end

    always_comb begin
        rd_val = DEFAULT_READ_VALUE;
        unique case (reg_sel)
            2'd0: rd_val = (count_q != '0) ? {23'd0, 1'b1, mem[rptr_q]} : 32'd0;
            2'd1: rd_val = {22'd0, fe_q, ovr_q, 8'd0} | 32'(count_q);
            2'd2: rd_val = {7'd0, thr_q, 2'b00, int_en_q, rx_en_q, div_q};
            default: rd_val = DEFAULT_READ_VALUE;
        endcase
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
        if (!WB_RST_n) begin
            ack_q  <= 1'b0;
            rd_q   <= '0;
            Intr_o <= 1'b0;
        end else begin
            ack_q <= access;
            if (rd_acc) rd_q <= rd_val;
            Intr_o <= int_en_q & ((32'(count_q) >= 32'(thr_q)) | ovr_q | fe_q);
        end
    end

    assign wb.WBs_ACK_o    = ack_q;
    assign wb.WBs_RD_DAT_o = rd_q;
endmodule

// File: tb/tb_uart_rx_wb.sv
// Testbench for uart_rx_wb. It applies a register vector table, then hand-built frame corner
// cases, then random byte bursts that are checked against a queue model of the receive FIFO.
module tb_uart_rx_wb;
    logic clk, rst_n, sin, intr;
    uart_rx_wb_if wb ();

    uart_rx_wb #(.FIFO_ADDR_W(4)) dut (
        .WB_CLK(clk), .WB_RST_n(rst_n), .wb(wb), .SIN_i(sin), .Intr_o(intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  addr;
        bit          we;
        logic [31:0] wdat;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vt [NV];

    logic [7:0]  q [$];
    bit          ovr_m;
    logic [31:0] d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [3:0] a, input bit we, input logic [31:0] wd,
                           input logic [3:0] be, output logic [31:0] rd);
        bit got;
        got = 0;
        rd  = '0;
        wb.WBs_ADR_i = a; wb.WBs_WE_i = we; wb.WBs_WR_DAT_i = wd; wb.WBs_BYTE_STB_i = be;
        wb.WBs_CYC_i = 1'b1; wb.WBs_STB_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb.WBs_ACK_o) begin
                got = 1;
                rd  = wb.WBs_RD_DAT_o;
                break;
            end
        end
        wb.WBs_CYC_i = 1'b0; wb.WBs_STB_i = 1'b0; wb.WBs_WE_i = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: addr %h, no ack within 8 cycles", a);
        end
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] rd);
        wb_xfer(a, 1'b0, 32'd0, 4'hF, rd);
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] unused_rd;
        wb_xfer(a, 1'b1, wd, be, unused_rd);
    endtask

    // Drives one 8N1 frame. With a low stop bit the line is left low for the caller.
    task automatic send_byte(input logic [7:0] b, input bit stop, input int bclks);
        sin = 1'b0;
        repeat (bclks) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            sin = b[k];
            repeat (bclks) @(negedge clk);
        end
        sin = stop;
        repeat (bclks) @(negedge clk);
        if (stop) sin = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", checks);
        $fatal(1);
    end

    initial begin
        vt[0]  = '{4'h0, 1'b0, 32'h0,        4'hF, 32'h0};
        vt[1]  = '{4'h4, 1'b0, 32'h0,        4'hF, 32'h0};
        vt[2]  = '{4'h8, 1'b0, 32'h0,        4'hF, 32'h0010_0001};
        vt[3]  = '{4'hC, 1'b0, 32'h0,        4'hF, 32'hBADF_ABAC};
        vt[4]  = '{4'hC, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[5]  = '{4'hC, 1'b0, 32'h0,        4'hF, 32'hBADF_ABAC};
        vt[6]  = '{4'h4, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vt[7]  = '{4'h4, 1'b0, 32'h0,        4'hF, 32'h0};
        vt[8]  = '{4'h8, 1'b1, 32'h00F0_1234, 4'h1, 32'h0};
        vt[9]  = '{4'h8, 1'b0, 32'h0,        4'hF, 32'h0010_0034};
        vt[10] = '{4'h8, 1'b1, 32'hFFFF_FFFF, 4'h2, 32'h0};
        vt[11] = '{4'h8, 1'b0, 32'h0,        4'hF, 32'h0010_FF34};
        vt[12] = '{4'h8, 1'b1, 32'h0120_0000, 4'hC, 32'h0};
        vt[13] = '{4'h8, 1'b0, 32'h0,        4'hF, 32'h0120_FF34};
        vt[14] = '{4'hB, 1'b0, 32'h0,        4'hF, 32'h0120_FF34};

        sin = 1'b1; rst_n = 1'b0;
        wb.WBs_ADR_i = '0; wb.WBs_CYC_i = 1'b0; wb.WBs_STB_i = 1'b0; wb.WBs_WE_i = 1'b0;
        wb.WBs_BYTE_STB_i = '0; wb.WBs_WR_DAT_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb.WBs_ACK_o), 32'd0);
        check("rst_rd", wb.WBs_RD_DAT_o, 32'd0);
        check("rst_intr", 32'(intr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            if (vt[i].we) wb_write(vt[i].addr, vt[i].wdat, vt[i].be);
            else begin
                wb_read(vt[i].addr, d);
                check($sformatf("vec%0d_rd", i), d, vt[i].exp);
            end
            @(negedge clk);
            check($sformatf("vec%0d_single_ack", i), 32'(wb.WBs_ACK_o), 32'd0);
            check($sformatf("vec%0d_intr", i), 32'(intr), 32'd0);
        end

        // Single byte at divisor 4 (64 clocks per bit), threshold 1.
        wb_write(4'h8, 32'h0013_0004, 4'hF);
        send_byte(8'hA5, 1'b1, 64);
        repeat (4) @(negedge clk);
        wb_read(4'h4, d);       check("single_count", d, 32'd1);
        check("single_intr_on", 32'(intr), 32'd1);
        wb_read(4'h0, d);       check("single_rxdata", d, 32'h1A5);
        repeat (2) @(negedge clk);
        check("single_intr_off", 32'(intr), 32'd0);
        wb_read(4'h4, d);       check("single_count0", d, 32'd0);
        wb_read(4'h0, d);       check("empty_rxdata", d, 32'd0);

        // Bad stop bit with the line held low for three bit-times, then released.
        send_byte(8'h3C, 1'b0, 64);
        repeat (128) @(negedge clk);
        sin = 1'b1;
        repeat (64 * 12) @(negedge clk);
        wb_read(4'h4, d);       check("fe_status", d, 32'h200);
        check("fe_intr", 32'(intr), 32'd1);
        wb_write(4'h4, 32'h200, 4'h2);
        wb_read(4'h4, d);       check("fe_cleared", d, 32'd0);
        send_byte(8'h5A, 1'b1, 64);
        repeat (4) @(negedge clk);
        wb_read(4'h0, d);       check("after_break_rx", d, 32'h15A);

        // Two-tick low pulse on an idle line.
        sin = 1'b0;
        repeat (8) @(negedge clk);
        sin = 1'b1;
        repeat (64 * 12) @(negedge clk);
        wb_read(4'h4, d);       check("glitch_status", d, 32'd0);

        // Overrun at divisor 1: 17 bytes with no reads.
        wb_write(4'h8, 32'h0013_0001, 4'hF);
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, 16);
        repeat (8) @(negedge clk);
        wb_read(4'h4, d);       check("ovr_status", d, 32'h110);
        for (int i = 0; i < 16; i++) begin
            wb_read(4'h0, d);
            check($sformatf("ovr_rd%0d", i), d, 32'h100 | 32'(i));
        end
        wb_write(4'h4, 32'h100, 4'h2);
        wb_read(4'h4, d);       check("ovr_cleared", d, 32'd0);

        // Full FIFO: the ACK edge of a pop lands on the push edge of the next byte.
        // The start edge is seen by the FSM 3 edges after the line falls. The stop sample
        // comes 152 ticks later and the push one edge after that, so the push is edge 156.
        for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b1, 16);
        repeat (4) @(negedge clk);
        fork
            send_byte(8'h77, 1'b1, 16);
            begin
                repeat (155) @(negedge clk);
                wb_read(4'h0, d);
                check("fullpop_rd", d, 32'h180);
            end
        join
        repeat (4) @(negedge clk);
        wb_read(4'h4, d);       check("fullpop_status", d, 32'h010);
        for (int i = 1; i < 16; i++) begin
            wb_read(4'h0, d);
            check($sformatf("fullpop_rd%0d", i), d, 32'h180 | 32'(i));
        end
        wb_read(4'h0, d);       check("fullpop_last", d, 32'h177);

        // Receiver disabled in the middle of a frame, then enabled again.
        fork
            send_byte(8'hC3, 1'b1, 16);
            begin
                repeat (60) @(negedge clk);
                wb_write(4'h8, 32'h0012_0001, 4'hF);
            end
        join
        wb_write(4'h8, 32'h0013_0001, 4'hF);
        repeat (20) @(negedge clk);
        wb_read(4'h4, d);       check("rxen_status", d, 32'd0);
        begin
            logic [7:0] b;
            b = 8'($urandom);
            send_byte(b, 1'b1, 16);
            repeat (4) @(negedge clk);
            wb_read(4'h0, d);   check("rxen_reenable_rx", d, 32'h100 | 32'(b));
        end

        // Random bursts against a queue model of the FIFO.
        for (int r = 0; r < 6; r++) begin
            int div, nb, bclks;
            logic [7:0] b;
            div   = $urandom_range(0, 2);
            nb    = $urandom_range(1, 18);
            bclks = 16 * ((div == 0) ? 1 : div);
            q.delete();
            ovr_m = 0;
            wb_write(4'h8, 32'h0013_0000 | 32'(div), 4'hF);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                send_byte(b, 1'b1, bclks);
                if (q.size() < 16) q.push_back(b);
                else               ovr_m = 1;
            end
            repeat (4) @(negedge clk);
            wb_read(4'h4, d);
            check($sformatf("rnd%0d_status", r), d, (ovr_m ? 32'h100 : 32'h0) | 32'(q.size()));
            check($sformatf("rnd%0d_intr", r), 32'(intr), 32'd1);
            while (q.size() > 0) begin
                logic [7:0] e;
                e = q.pop_front();
                wb_read(4'h0, d);
                check($sformatf("rnd%0d_rx", r), d, 32'h100 | 32'(e));
            end
            wb_read(4'h0, d);
            check($sformatf("rnd%0d_empty", r), d, 32'd0);
            wb_write(4'h4, 32'h300, 4'h2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
